reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of ROB entries (power of two).
REQ-002 SHALL have parameter TAG_W, default 3, entry index width (log2 DEPTH).
REQ-003 SHALL have parameter REG_W, default 4, architectural register index width (16 registers).
REQ-004 SHALL have parameter DATA_W, default 16, result width.
REQ-005 SHALL have port clk1  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port alloc_valid  input  1  issue stage requests an entry.
REQ-008 SHALL have port alloc_dest  input  REG_W  destination register of the issued instruction.
REQ-009 SHALL have port alloc_ready  output  1  entry available (combinational, count < DEPTH and rst low).
REQ-010 SHALL have port alloc_tag  output  TAG_W  tag granted (equals tail pointer).
REQ-011 SHALL have ports cdb_valid  input  1, cdb_tag  input  TAG_W, cdb_data  input  DATA_W  common data bus broadcast from add/mul units.
REQ-012 SHALL have ports src_tag  input  TAG_W, src_ready  output  1, src_data  output  DATA_W  combinational operand lookup for reservation stations.
REQ-013 SHALL have ports commit_valid  output  1, commit_dest  output  REG_W, commit_data  output  DATA_W  registered register-bank write.
REQ-014 SHALL have port flush  input  1  discard all in-flight entries.
REQ-015 SHALL have port count  output  TAG_W+1  occupied entries, 0..DEPTH.

Function
REQ-016 SHALL hold per entry: busy, ready, dest, value.
REQ-017 SHALL allocate when alloc_valid && alloc_ready: entry[tail] <= busy=1, ready=0, dest=alloc_dest; tail increments modulo DEPTH (7 -> 0).
REQ-018 SHALL ignore alloc_valid when alloc_ready is low; no state change.
REQ-019 SHALL compute alloc_ready from pre-edge count only; a commit in the same cycle does not enable allocation when full.
REQ-020 SHALL, on cdb_valid with entry[cdb_tag] busy and not ready, set ready=1 and value=cdb_data; broadcasts to non-busy or already-ready entries are ignored.
REQ-021 SHALL commit at an edge when the pre-edge entry[head] is busy and ready: clear busy, head increments modulo DEPTH, commit_valid<=1, commit_dest<=dest, commit_data<=value.
REQ-022 SHALL commit at most one entry per cycle, strictly in allocation order; commit_valid<=0 at edges with no commit.
REQ-023 SHALL give CDB-to-commit latency of two edges: CDB captured at edge N, commit at edge N+1, commit_valid high between N+1 and N+2.
REQ-024 SHALL update count <= count + alloc - commit; simultaneous alloc and commit leaves count unchanged.
REQ-025 SHALL drive src_ready = entry[src_tag].busy && ready and src_data = entry[src_tag].value; no same-cycle CDB bypass.
REQ-026 SHALL, on flush, clear all busy/ready, set head=tail=0, count=0, commit_valid<=0; flush overrides alloc, CDB and commit in that cycle.
REQ-027 SHALL treat head==tail as empty when count==0 and full when count==DEPTH.

Reset
REQ-028 SHALL, while rst high at an edge: head=0, tail=0, count=0, all busy/ready=0, commit_valid=0, commit_dest=0, commit_data=0.
REQ-029 SHALL hold alloc_ready=0 while rst high; alloc_ready=1 in the first cycle after release.
REQ-030 SHALL give rst priority over flush and all other inputs, including mid-operation with a full buffer.

Structure
REQ-031 SHALL take DEPTH, TAG_W, REG_W, DATA_W defaults and the rob_entry_t typedef (busy, ready, dest, value) from shared package tomasulo_pkg.
REQ-032 SHALL instantiate sub-module rob_ptr_ctr (wrap-around pointer with increment and clear) twice, for head and tail.

Verification
REQ-033 Reset then 8 allocs (dest 1..8) -> tags 0..7, count=8, alloc_ready=0; 9th alloc ignored.
REQ-034 Alloc tags 0,1; CDB tag1=0x22 then tag0=0x11 -> commit (dest1,0x11) then (dest2,0x22) on consecutive cycles, in order.
REQ-035 Full buffer, head ready, alloc_valid same cycle -> commit occurs, alloc rejected, count 8->7.
REQ-036 Wrap: alloc/commit 10 instructions one at a time -> tail/head wrap 7->0, tags repeat 0,1, data correct.
REQ-037 CDB to unallocated tag 5 with data 0xFF -> no state change, src_ready for tag 5 stays 0.
REQ-038 4 entries busy, flush (or rst) mid-stream -> count=0, commit_valid=0, next alloc gets tag 0.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared reorder-buffer sizes and entry type
// Purpose : default ROB geometry and the per-entry record used by reorder_buffer.
// Contents: ROB_DEPTH, ROB_TAG_W, ROB_REG_W, ROB_DATA_W, rob_entry_t.
package tomasulo_pkg;

   localparam int ROB_DEPTH  = 8;
   localparam int ROB_TAG_W  = 3;
   localparam int ROB_REG_W  = 4;
   localparam int ROB_DATA_W = 16;

   typedef struct packed {
      logic                  busy;
      logic                  ready;
      logic [ROB_REG_W-1:0]  dest;
      logic [ROB_DATA_W-1:0] value;
   } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctr.sv
// rtl/rob_ptr_ctr.sv - wrap-around ROB pointer with increment and clear
// Purpose : W-bit pointer that wraps naturally at 2**W.
// Ports   : i_clk   - clock
//           i_rst   - synchronous active-high reset (pointer to 0)
//           i_clr   - synchronous clear (pointer to 0)
//           i_inc   - advance pointer by one
//           o_ptr   - current pointer value
module rob_ptr_ctr #(
   parameter int W = 3
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_ptr
);

   logic [W-1:0] r_ptr;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         r_ptr <= r_ptr + 1'b1;
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order commit reorder buffer for a Tomasulo core
// Purpose : allocates entries at tail, captures CDB results, retires head in order.
// Ports   : clk1, rst                        - clock, sync active-high reset
//           alloc_valid/dest/ready/tag       - issue-side allocation handshake
//           cdb_valid/tag/data               - result broadcast
//           src_tag/ready/data               - combinational operand lookup
//           commit_valid/dest/data           - registered register-bank write
//           flush                            - discard all in-flight entries
//           count                            - occupied entries, 0..DEPTH
module reorder_buffer #(
   parameter int DEPTH  = tomasulo_pkg::ROB_DEPTH,
   parameter int TAG_W  = tomasulo_pkg::ROB_TAG_W,
   parameter int REG_W  = tomasulo_pkg::ROB_REG_W,
   parameter int DATA_W = tomasulo_pkg::ROB_DATA_W
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              alloc_valid,
   input  logic [REG_W-1:0]  alloc_dest,
   output logic              alloc_ready,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic [TAG_W-1:0]  src_tag,
   output logic              src_ready,
   output logic [DATA_W-1:0] src_data,
   output logic              commit_valid,
   output logic [REG_W-1:0]  commit_dest,
   output logic [DATA_W-1:0] commit_data,
   input  logic              flush,
   output logic [TAG_W:0]    count
);
   import tomasulo_pkg::*;

   rob_entry_t        r_rob [DEPTH];
   logic [TAG_W:0]    r_count;
   logic              r_commit_valid;
   logic [REG_W-1:0]  r_commit_dest;
   logic [DATA_W-1:0] r_commit_data;

   logic [TAG_W-1:0]  w_head;
   logic [TAG_W-1:0]  w_tail;
   logic              w_alloc;
   logic              w_commit;

   // Readiness uses the pre-edge count only, so a full buffer never frees a
   // slot for an allocation in the same cycle as a commit.
   assign alloc_ready = (r_count < (TAG_W+1)'(DEPTH)) && !rst;
   assign alloc_tag   = w_tail;
   assign w_alloc     = alloc_valid && alloc_ready;
   assign w_commit    = r_rob[w_head].busy && r_rob[w_head].ready;

   rob_ptr_ctr #(.W(TAG_W)) u_head (
      .i_clk (clk1),
      .i_rst (rst),
      .i_clr (flush),
      .i_inc (w_commit && !flush),
      .o_ptr (w_head)
   );

   rob_ptr_ctr #(.W(TAG_W)) u_tail (
      .i_clk (clk1),
      .i_rst (rst),
      .i_clr (flush),
      .i_inc (w_alloc && !flush),
      .o_ptr (w_tail)
   );

   // Alloc, commit and CDB never target the same field of one entry in a
   // cycle: tail==head with a busy head only happens when full (alloc
   // blocked), and the CDB only writes entries that are busy and not ready.
   always_ff @(posedge clk1) begin
      if (rst || flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_rob[i].busy  <= 1'b0;
            r_rob[i].ready <= 1'b0;
         end
      end else begin
         if (w_commit) begin
            r_rob[w_head].busy  <= 1'b0;
            r_rob[w_head].ready <= 1'b0;
         end
         if (w_alloc) begin
            r_rob[w_tail].busy  <= 1'b1;
            r_rob[w_tail].ready <= 1'b0;
            r_rob[w_tail].dest  <= alloc_dest;
         end
         if (cdb_valid && r_rob[cdb_tag].busy && !r_rob[cdb_tag].ready) begin
            r_rob[cdb_tag].ready <= 1'b1;
            r_rob[cdb_tag].value <= cdb_data;
         end
      end
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         r_count        <= '0;
         r_commit_valid <= 1'b0;
         r_commit_dest  <= '0;
         r_commit_data  <= '0;
      end else if (flush) begin
         r_count        <= '0;
         r_commit_valid <= 1'b0;
      end else begin
         r_count        <= r_count + (TAG_W+1)'(w_alloc) - (TAG_W+1)'(w_commit);
         r_commit_valid <= w_commit;
         if (w_commit) begin
            r_commit_dest <= r_rob[w_head].dest;
            r_commit_data <= r_rob[w_head].value;
         end
      end
   end

   // No CDB bypass: a result becomes visible to operand lookup the cycle
   // after it is captured.
   assign src_ready    = r_rob[src_tag].busy && r_rob[src_tag].ready;
   assign src_data     = r_rob[src_tag].value;
   assign commit_valid = r_commit_valid;
   assign commit_dest  = r_commit_dest;
   assign commit_data  = r_commit_data;
   assign count        = r_count;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;

   logic        clk1 = 1'b0;
   logic        rst;
   logic        alloc_valid;
   logic [3:0]  alloc_dest;
   logic        alloc_ready;
   logic [2:0]  alloc_tag;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [15:0] cdb_data;
   logic [2:0]  src_tag;
   logic        src_ready;
   logic [15:0] src_data;
   logic        commit_valid;
   logic [3:0]  commit_dest;
   logic [15:0] commit_data;
   logic        flush;
   logic [3:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk1 = ~clk1;

   reorder_buffer dut (
      .clk1         (clk1),
      .rst          (rst),
      .alloc_valid  (alloc_valid),
      .alloc_dest   (alloc_dest),
      .alloc_ready  (alloc_ready),
      .alloc_tag    (alloc_tag),
      .cdb_valid    (cdb_valid),
      .cdb_tag      (cdb_tag),
      .cdb_data     (cdb_data),
      .src_tag      (src_tag),
      .src_ready    (src_ready),
      .src_data     (src_data),
      .commit_valid (commit_valid),
      .commit_dest  (commit_dest),
      .commit_data  (commit_data),
      .flush        (flush),
      .count        (count)
   );

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One allocation cycle: checks the granted tag before the edge.
   task automatic do_alloc(input logic [3:0] dest, input logic [2:0] exp_tag, input string tag);
      alloc_valid = 1'b1;
      alloc_dest  = dest;
      #1;
      chk({tag, "_tag"}, alloc_tag, exp_tag);
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic do_cdb(input logic [2:0] t, input logic [15:0] d);
      cdb_valid = 1'b1;
      cdb_tag   = t;
      cdb_data  = d;
      tick();
      cdb_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; alloc_valid = 1'b0; alloc_dest = '0; cdb_valid = 1'b0;
      cdb_tag = '0; cdb_data = '0; src_tag = '0; flush = 1'b0;
      tick();
      tick();
      // Reset state
      chk("rst_alloc_ready", alloc_ready, 0);
      chk("rst_count", count, 0);
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_commit_dest", commit_dest, 0);
      chk("rst_commit_data", commit_data, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_alloc_ready", alloc_ready, 1);

      // Fill: 8 allocs dest 1..8 get tags 0..7
      for (int i = 0; i < 8; i++) do_alloc(4'(i + 1), 3'(i), "fill");
      chk("full_count", count, 8);
      chk("full_alloc_ready", alloc_ready, 0);
      src_tag = 3'd0; #1;
      chk("full_src_ready0", src_ready, 0);
      alloc_valid = 1'b1; alloc_dest = 4'd9;
      tick();
      alloc_valid = 1'b0;
      chk("ninth_count", count, 8);
      chk("ninth_tail", alloc_tag, 0);

      flush = 1'b1; tick(); flush = 1'b0;
      chk("flush_full_count", count, 0);
      chk("flush_full_ready", alloc_ready, 1);

      // Out-of-order completion, in-order commit
      do_alloc(4'd1, 3'd0, "ooo0");
      do_alloc(4'd2, 3'd1, "ooo1");
      do_cdb(3'd1, 16'h0022);
      src_tag = 3'd1; #1;
      chk("ooo_src_ready1", src_ready, 1);
      chk("ooo_src_data1", src_data, 16'h0022);
      chk("ooo_no_commit_yet", commit_valid, 0);
      do_cdb(3'd0, 16'h0011);
      chk("ooo_no_commit_cdb0", commit_valid, 0);
      tick();
      chk("ooo_c0_valid", commit_valid, 1);
      chk("ooo_c0_dest", commit_dest, 1);
      chk("ooo_c0_data", commit_data, 16'h0011);
      chk("ooo_c0_count", count, 1);
      tick();
      chk("ooo_c1_valid", commit_valid, 1);
      chk("ooo_c1_dest", commit_dest, 2);
      chk("ooo_c1_data", commit_data, 16'h0022);
      chk("ooo_c1_count", count, 0);
      tick();
      chk("ooo_idle_valid", commit_valid, 0);

      // CDB to an unallocated tag is ignored
      do_cdb(3'd5, 16'h00FF);
      src_tag = 3'd5; #1;
      chk("stray_src_ready5", src_ready, 0);
      chk("stray_count", count, 0);
      tick();
      chk("stray_commit_valid", commit_valid, 0);

      // Wrap: 10 single instructions from tag 0
      flush = 1'b1; tick(); flush = 1'b0;
      for (int i = 0; i < 10; i++) begin
         do_alloc(4'((i + 3) % 16), 3'(i % 8), "wrap");
         chk("wrap_gap_valid", commit_valid, 0);
         do_cdb(3'(i % 8), 16'h0100 + 16'(i));
         tick();
         chk("wrap_valid", commit_valid, 1);
         chk("wrap_dest", commit_dest, 32'((i + 3) % 16));
         chk("wrap_data", commit_data, 32'h0100 + 32'(i));
         chk("wrap_count", count, 0);
      end

      // Full buffer with ready head: commit wins, alloc rejected
      for (int i = 0; i < 8; i++) do_alloc(4'(i), 3'((i + 2) % 8), "full2");
      do_cdb(3'd2, 16'h0055);
      alloc_valid = 1'b1; alloc_dest = 4'hF;
      #1;
      chk("fc_pre_ready", alloc_ready, 0);
      tick();
      alloc_valid = 1'b0;
      chk("fc_count", count, 7);
      chk("fc_commit_valid", commit_valid, 1);
      chk("fc_commit_data", commit_data, 16'h0055);
      chk("fc_commit_dest", commit_dest, 0);
      chk("fc_tail_held", alloc_tag, 2);

      // Reset mid-operation beats flush and alloc
      rst = 1'b1; flush = 1'b1; alloc_valid = 1'b1;
      tick();
      rst = 1'b0; flush = 1'b0; alloc_valid = 1'b0;
      chk("midrst_count", count, 0);
      chk("midrst_commit_valid", commit_valid, 0);
      chk("midrst_commit_data", commit_data, 0);
      do_alloc(4'd7, 3'd0, "midrst_next");

      // 4 busy, flush with concurrent CDB
      do_alloc(4'd8, 3'd1, "fl4");
      do_alloc(4'd9, 3'd2, "fl4");
      do_alloc(4'd10, 3'd3, "fl4");
      chk("fl4_count_pre", count, 4);
      flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 16'hABCD;
      alloc_valid = 1'b1;
      tick();
      flush = 1'b0; cdb_valid = 1'b0; alloc_valid = 1'b0;
      chk("fl4_count", count, 0);
      chk("fl4_commit_valid", commit_valid, 0);
      src_tag = 3'd0; #1;
      chk("fl4_src_ready0", src_ready, 0);
      do_alloc(4'd1, 3'd0, "fl4_next");
      chk("fl4_next_count", count, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
